mii_mac_tx: RTL and testbench



---
 rtl/eth_pkg.sv | 34 +++
 rtl/crc32_d8.sv | 25 ++
 rtl/mii_mac_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_mii_mac_tx.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: MII framing nibbles, CRC-32 constants,
// default minimum frame length and the transmit FSM state encoding.
package eth_pkg;

    localparam logic [3:0]  PREAMBLE_NIB      = 4'h5;
    localparam logic [3:0]  SFD_NIB           = 4'hD;

    localparam logic [31:0] CRC32_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE     = 32'hDEBB20E3;

    localparam int          MIN_FRAME_DEFAULT = 60;

    typedef enum logic [3:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        ERR,
        DRAIN,
        IFG
    } tx_state_t;

    // FCS is the complemented CRC register, sent least significant nibble first.
    function automatic logic [3:0] fcs_nibble(input logic [31:0] crc,
                                              input logic [2:0]  idx);
        logic [31:0] fcs;
        fcs = ~crc;
        return fcs[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 step over one byte (LSB first).
// Ports: crc_i current register, data_i byte, crc_o next register.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/mii_mac_tx.sv
// MII transmit MAC: preamble/SFD, payload, zero pad, CRC-32 FCS and IFG.
// Ports: tx_clk/rst_n, AXI-Stream byte sink (s_axis_*), MII TXD/TX_EN/TX_ER,
// frame_sent and frame_abort status pulses.
module mii_mac_tx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME        = MIN_FRAME_DEFAULT,
    parameter int IFG_NIBBLES      = 24,
    parameter int PREAMBLE_NIBBLES = 15
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic [3:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       frame_sent,
    output logic       frame_abort
);

    localparam int               CNT_W    = 8;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_NIBBLES - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(7);
    localparam logic [5:0]       MIN_CNT  = 6'(MIN_FRAME);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             last_q, last_d;
    logic [7:0]       byte_q, byte_d;
    logic [5:0]       byte_cnt_q, byte_cnt_d;
    logic [5:0]       byte_cnt_inc;
    logic [31:0]      crc_q, crc_d, crc_next;
    logic [7:0]       crc_in;

    logic [3:0]       tx_data_q, tx_data_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic             sent_q, sent_d;
    logic             abort_q, abort_d;

    logic             accept;

    // Pad bytes are zeros fed through the same CRC path as data.
    assign crc_in = (state_q == PAD) ? 8'h00 : byte_q;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (crc_in),
        .crc_o  (crc_next)
    );

    assign byte_cnt_inc = (byte_cnt_q == 6'd63) ? byte_cnt_q
                                                : byte_cnt_q + 6'd1;

    // Byte fetch happens in SFD and in the high-nibble cycle of DATA,
    // so the next byte is ready for its low nibble one cycle later.
    always_comb begin
        s_axis_tready = 1'b0;
        unique case (state_q)
            SFD:     s_axis_tready = 1'b1;
            DATA:    s_axis_tready = phase_q & ~last_q;
            DRAIN:   s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

    assign accept = s_axis_tready & s_axis_tvalid;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        last_d     = last_q;
        byte_d     = byte_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        unique case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_d    = PREAMBLE;
                    cnt_d      = '0;
                    phase_d    = 1'b0;
                    last_d     = 1'b0;
                    byte_cnt_d = '0;
                    crc_d      = CRC32_INIT;
                end
            end
            PREAMBLE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SFD: begin
                if (accept) begin
                    state_d = DATA;
                    byte_d  = s_axis_tdata;
                    last_d  = s_axis_tlast;
                    phase_d = 1'b0;
                end else begin
                    state_d = ERR;
                end
            end
            DATA: begin
                if (!phase_q) begin
                    phase_d    = 1'b1;
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_inc;
                end else if (!last_q) begin
                    if (accept) begin
                        byte_d  = s_axis_tdata;
                        last_d  = s_axis_tlast;
                        phase_d = 1'b0;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    state_d = (byte_cnt_q < MIN_CNT) ? PAD : FCS;
                end
            end
            PAD: begin
                if (!phase_q) begin
                    phase_d    = 1'b1;
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_inc;
                end else begin
                    phase_d = 1'b0;
                    if (byte_cnt_q >= MIN_CNT) begin
                        state_d = FCS;
                        cnt_d   = '0;
                    end
                end
            end
            FCS: begin
                if (cnt_q == FCS_LAST) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (accept && s_axis_tlast) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered MII pins
    // line up with the state register.
    always_comb begin
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        tx_data_d = 4'h0;
        sent_d    = (state_q == FCS) && (state_d == IFG);
        abort_d   = (state_d == ERR);
        unique case (state_d)
            PREAMBLE: begin
                tx_en_d   = 1'b1;
                tx_data_d = PREAMBLE_NIB;
            end
            SFD: begin
                tx_en_d   = 1'b1;
                tx_data_d = SFD_NIB;
            end
            DATA: begin
                tx_en_d   = 1'b1;
                tx_data_d = phase_d ? byte_d[7:4] : byte_d[3:0];
            end
            PAD: begin
                tx_en_d = 1'b1;
            end
            FCS: begin
                tx_en_d   = 1'b1;
                tx_data_d = fcs_nibble(crc_d, cnt_d[2:0]);
            end
            ERR: begin
                tx_en_d = 1'b1;
                tx_er_d = 1'b1;
            end
            default: begin
                tx_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            last_q     <= 1'b0;
            byte_q     <= '0;
            byte_cnt_q <= '0;
            crc_q      <= CRC32_INIT;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            sent_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            last_q     <= last_d;
            byte_q     <= byte_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            sent_q     <= sent_d;
            abort_q    <= abort_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;
    assign tx_er       = tx_er_q;
    assign frame_sent  = sent_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_mii_mac_tx.sv
// Testbench for mii_mac_tx: table vectors, corner sequences and random frames
// checked against a byte-level frame model with a table-driven CRC-32.
`timescale 1ns/1ps
module tb_mii_mac_tx;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int len;
        int nstart;
        int bstart;
        int nbytes;
        int gap;
        bit pre_ok;
        bit res_ok;
        bit er;
        bit sent_ok;
    } burst_t;

    typedef struct {
        logic [7:0] din;
        logic [3:0] lo;
        logic [3:0] hi;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic [1:0][7:0] tdata;
    logic [1:0]      tvalid;
    logic [1:0]      tlast;
    wire  [1:0]      tready;
    wire  [1:0][3:0] txd;
    wire  [1:0]      txen;
    wire  [1:0]      txer;
    wire  [1:0]      sent;
    wire  [1:0]      abort;

    int errors = 0;
    int checks = 0;

    mii_mac_tx #(.MIN_FRAME(0)) u_dut0 (
        .tx_clk        (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (tdata[0]),
        .s_axis_tvalid (tvalid[0]),
        .s_axis_tlast  (tlast[0]),
        .s_axis_tready (tready[0]),
        .tx_data       (txd[0]),
        .tx_en         (txen[0]),
        .tx_er         (txer[0]),
        .frame_sent    (sent[0]),
        .frame_abort   (abort[0])
    );

    mii_mac_tx u_dut1 (
        .tx_clk        (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (tdata[1]),
        .s_axis_tvalid (tvalid[1]),
        .s_axis_tlast  (tlast[1]),
        .s_axis_tready (tready[1]),
        .tx_data       (txd[1]),
        .tx_en         (txen[1]),
        .tx_er         (txer[1]),
        .frame_sent    (sent[1]),
        .frame_abort   (abort[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] crc_tab [256];

    function automatic void build_table();
        logic [31:0] v;
        for (int n = 0; n < 256; n++) begin
            v = 32'(n);
            for (int k = 0; k < 8; k++) begin
                v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
            end
            crc_tab[n] = v;
        end
    endfunction

    function automatic logic [31:0] crc_bytes(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ b[i]];
        return c;
    endfunction

    // Expected on-wire frame: payload, zero pad to minf, FCS LSB byte first.
    function automatic bq_t model(input bq_t f, input int minf);
        bq_t         e;
        logic [31:0] c;
        e = f;
        while (e.size() < minf) e.push_back(8'h00);
        c = ~crc_bytes(e);
        for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: both DUTs idle at zero, so their outputs are OR-combined.
    wire       m_en    = txen[0] | txen[1];
    wire [3:0] m_d     = txd[0] | txd[1];
    wire       m_er    = txer[0] | txer[1];
    wire       m_sent  = sent[0] | sent[1];
    wire       m_abort = abort[0] | abort[1];

    logic [3:0] nib_log [$];
    logic [7:0] byte_log [$];
    burst_t     bursts [$];
    logic [3:0] cur [$];
    bit         cur_er;
    bit         prev_en;
    bit         have_prev;
    int         gap;
    int         start_gap;
    int         er_cycles = 0;
    int         sent_cnt  = 0;
    int         abort_cnt = 0;

    task automatic finish_burst(input bit s);
        burst_t b;
        bq_t    bytes;
        b.len     = cur.size();
        b.nstart  = nib_log.size();
        b.bstart  = byte_log.size();
        b.er      = cur_er;
        b.sent_ok = s;
        b.gap     = start_gap;
        b.pre_ok  = (b.len >= 16);
        for (int i = 0; i < 15 && i < b.len; i++)
            if (cur[i] !== 4'h5) b.pre_ok = 0;
        if (b.len >= 16 && cur[15] !== 4'hD) b.pre_ok = 0;
        for (int i = 16; i + 1 < b.len; i += 2)
            bytes.push_back({cur[i+1], cur[i]});
        b.nbytes = bytes.size();
        b.res_ok = (bytes.size() >= 4) &&
                   (crc_bytes(bytes) == 32'hDEBB20E3);
        foreach (cur[i]) nib_log.push_back(cur[i]);
        foreach (bytes[i]) byte_log.push_back(bytes[i]);
        bursts.push_back(b);
        cur.delete();
        cur_er = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cur.delete();
            cur_er    = 0;
            prev_en   = 0;
            have_prev = 0;
            gap       = 0;
        end else begin
            if (m_en) begin
                if (!prev_en) start_gap = have_prev ? gap : -1;
                cur.push_back(m_d);
                if (m_er) cur_er = 1;
            end else if (prev_en) begin
                finish_burst(m_sent);
                have_prev = 1;
                gap = 1;
            end else begin
                gap++;
            end
            prev_en = m_en;
            if (m_er) er_cycles++;
            if (m_sent) sent_cnt++;
            if (m_abort) abort_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic push(input int d, input logic [7:0] b, input logic l);
        int t;
        t = 0;
        tdata[d]  = b;
        tlast[d]  = l;
        tvalid[d] = 1'b1;
        while (!tready[d] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: tready got 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input int d, input bq_t f, input bit hold);
        foreach (f[i]) push(d, f[i], (i == f.size() - 1));
        if (!hold) begin
            tvalid[d] = 1'b0;
            tlast[d]  = 1'b0;
        end
    endtask

    task automatic wait_bursts(input int n);
        int t;
        t = 0;
        while (bursts.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("burst_timeout", bursts.size() >= n, 1);
    endtask

    task automatic check_frame(input int bi, input bq_t f, input int minf,
                               input string name);
        bq_t    e;
        burst_t b;
        int     mism;
        e = model(f, minf);
        mism = 0;
        if (bi >= bursts.size()) begin
            chk({name, "_present"}, 0, 1);
            return;
        end
        b = bursts[bi];
        chk({name, "_len"}, b.len, 16 + 2 * e.size());
        chk({name, "_preamble"}, b.pre_ok, 1);
        chk({name, "_nbytes"}, b.nbytes, e.size());
        for (int i = 0; i < e.size() && i < b.nbytes; i++)
            if (byte_log[b.bstart + i] !== e[i]) mism++;
        chk({name, "_byte_mism"}, mism, 0);
        chk({name, "_residue"}, b.res_ok, 1);
        chk({name, "_er"}, b.er, 0);
        chk({name, "_sent"}, b.sent_ok, 1);
    endtask

    function automatic bq_t rnd_frame(input int n);
        bq_t f;
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
        return f;
    endfunction

    initial begin
        vec_t       tab [9];
        logic [3:0] fcs_tab [8];
        bq_t        f;
        bq_t        f2;
        bq_t        rnd_flat;
        int         rnd_len [8];
        burst_t     b;
        int         nb, s0, e0, a0, nz, pos;

        build_table();
        tdata  = '0;
        tvalid = '0;
        tlast  = '0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            chk("reset_tx_en", txen[d], 0);
            chk("reset_tx_er", txer[d], 0);
            chk("reset_tx_data", txd[d], 0);
            chk("reset_sent", sent[d], 0);
            chk("reset_abort", abort[d], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tready0", tready[0], 0);
        chk("idle_tready1", tready[1], 0);

        // "123456789" on the MIN_FRAME=0 instance, nibble by nibble.
        tab[0] = '{8'h31, 4'h1, 4'h3};
        tab[1] = '{8'h32, 4'h2, 4'h3};
        tab[2] = '{8'h33, 4'h3, 4'h3};
        tab[3] = '{8'h34, 4'h4, 4'h3};
        tab[4] = '{8'h35, 4'h5, 4'h3};
        tab[5] = '{8'h36, 4'h6, 4'h3};
        tab[6] = '{8'h37, 4'h7, 4'h3};
        tab[7] = '{8'h38, 4'h8, 4'h3};
        tab[8] = '{8'h39, 4'h9, 4'h3};
        fcs_tab = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        f.delete();
        foreach (tab[i]) f.push_back(tab[i].din);
        nb = bursts.size();
        s0 = sent_cnt;
        send_frame(0, f, 0);
        wait_bursts(nb + 1);
        b = bursts[nb];
        chk("t1_len", b.len, 42);
        chk("t1_sent_timing", b.sent_ok, 1);
        if (b.len == 42) begin
            for (int i = 0; i < 16; i++)
                chk("t1_preamble", nib_log[b.nstart + i],
                    (i < 15) ? 4'h5 : 4'hD);
            foreach (tab[i]) begin
                chk("t1_lo", nib_log[b.nstart + 16 + 2*i], tab[i].lo);
                chk("t1_hi", nib_log[b.nstart + 17 + 2*i], tab[i].hi);
            end
            foreach (fcs_tab[k])
                chk("t1_fcs", nib_log[b.nstart + 34 + k], fcs_tab[k]);
        end
        repeat (30) @(negedge clk);
        chk("t1_sent_once", sent_cnt - s0, 1);

        // 14-byte frame: padded to 60, 144 enabled cycles.
        f = rnd_frame(14);
        nb = bursts.size();
        send_frame(1, f, 0);
        wait_bursts(nb + 1);
        chk("t2_len144", bursts[nb].len, 144);
        check_frame(nb, f, 60, "t2");
        nz = 0;
        for (int i = 14; i < 60; i++)
            if (byte_log[bursts[nb].bstart + i] !== 8'h00) nz++;
        chk("t2_pad_zero", nz, 0);

        // Back-to-back 60-byte frames with tvalid held.
        f  = rnd_frame(60);
        f2 = rnd_frame(60);
        repeat (30) @(negedge clk);
        nb = bursts.size();
        s0 = sent_cnt;
        e0 = er_cycles;
        send_frame(1, f, 1);
        send_frame(1, f2, 0);
        wait_bursts(nb + 2);
        check_frame(nb, f, 60, "t3a");
        check_frame(nb + 1, f2, 60, "t3b");
        chk("t3_gap", bursts[nb + 1].gap, 25);
        chk("t3_sent2", sent_cnt - s0, 2);
        chk("t3_no_er", er_cycles - e0, 0);

        // Underrun at byte 20 of a 64-byte frame, then drain and recover.
        f = rnd_frame(64);
        repeat (30) @(negedge clk);
        nb = bursts.size();
        s0 = sent_cnt;
        e0 = er_cycles;
        a0 = abort_cnt;
        for (int i = 0; i < 20; i++) push(1, f[i], 1'b0);
        tvalid[1] = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 20; i < 64; i++) push(1, f[i], (i == 63));
        tvalid[1] = 1'b0;
        tlast[1]  = 1'b0;
        wait_bursts(nb + 1);
        chk("t4_abort_len", bursts[nb].len, 57);
        chk("t4_abort_er", bursts[nb].er, 1);
        chk("t4_no_sent", bursts[nb].sent_ok, 0);
        chk("t4_er_cycles", er_cycles - e0, 1);
        chk("t4_abort_pulse", abort_cnt - a0, 1);
        chk("t4_sent_none", sent_cnt - s0, 0);
        f2 = rnd_frame(64);
        send_frame(1, f2, 0);
        wait_bursts(nb + 2);
        check_frame(nb + 1, f2, 60, "t4_next");
        chk("t4_gap", bursts[nb + 1].gap >= 25, 1);

        // Reset in the middle of DATA.
        repeat (30) @(negedge clk);
        f = rnd_frame(30);
        for (int i = 0; i < 10; i++) push(1, f[i], 1'b0);
        a0 = abort_cnt;
        rst_n     = 1'b0;
        tvalid[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t5_rst_en", txen[1], 0);
            chk("t5_rst_er", txer[1], 0);
            chk("t5_rst_data", txd[1], 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_no_abort", abort_cnt - a0, 0);
        nb = bursts.size();
        f2 = rnd_frame(25);
        send_frame(1, f2, 0);
        wait_bursts(nb + 1);
        check_frame(nb, f2, 60, "t5_after");

        // Single-byte frame padded to the minimum.
        repeat (30) @(negedge clk);
        f.delete();
        f.push_back(8'hA7);
        nb = bursts.size();
        send_frame(1, f, 0);
        wait_bursts(nb + 1);
        chk("t6_len144", bursts[nb].len, 144);
        check_frame(nb, f, 60, "t6");

        // Random frames, sometimes back-to-back.
        repeat (30) @(negedge clk);
        nb = bursts.size();
        for (int r = 0; r < 8; r++) begin
            int L;
            bit hold;
            L = $urandom_range(1, 90);
            hold = (r < 7) && ($urandom_range(0, 1) == 1);
            f = rnd_frame(L);
            rnd_len[r] = L;
            foreach (f[i]) rnd_flat.push_back(f[i]);
            send_frame(1, f, hold);
            if (!hold) repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_bursts(nb + 8);
        pos = 0;
        for (int r = 0; r < 8; r++) begin
            f.delete();
            for (int i = 0; i < rnd_len[r]; i++) begin
                f.push_back(rnd_flat[pos]);
                pos++;
            end
            check_frame(nb + r, f, 60, "rnd");
        end

        repeat (40) @(negedge clk);
        chk("no_extra_bursts", bursts.size(), nb + 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
